adc_conv_sequencer: RTL and testbench

- Digital conversion sequencer, directly upstream of the self-clocked clock generator / edge-detect macro in adc_top.
- Runs on the always-on clk_vcm domain. Drives the generator's enable, start pulse and delay configuration.
- Watches the comparator-side "conversion finished" flag, captures the SAR result and averages 2^osr conversions.
- Delivers each averaged sample over a valid/ready port and flags timeout and overrun errors.

---
 rtl/adc_conv_sequencer_pkg.sv | 25 ++
 rtl/adc_conv_sequencer_if.sv | 13 +
 rtl/adc_conv_sequencer_sync_edge.sv | 25 ++
 rtl/adc_conv_sequencer.sv | 173 +++++++++++++++++
 tb/tb_adc_conv_sequencer.sv | 361 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/adc_conv_sequencer_pkg.sv
// Shared types and width helpers for the ADC conversion sequencer.
package adc_seq_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ARM     = 3'd1,
        START   = 3'd2,
        WAIT    = 3'd3,
        CAPTURE = 3'd4,
        DONE    = 3'd5
    } seq_state_t;

    // Seven guard bits hold the sum of up to 2^7 full-scale codes.
    localparam int ACC_EXTRA = 7;
    localparam int PERIOD_W  = 16;

    function automatic int acc_width(input int result_w);
        return result_w + ACC_EXTRA;
    endfunction

    function automatic int tmo_width(input int timeout);
        return $clog2(timeout);
    endfunction

endpackage

// File: rtl/adc_conv_sequencer_if.sv
// Averaged-sample output port of the conversion sequencer.
interface adc_conv_sequencer_if #(
    parameter int RESULT_W = 12
) ();
    // Handshake: a sample transfers on a clock edge where data_valid_out and
    // data_ready_in are both 1; data_out is stable while valid waits for ready.
    logic [RESULT_W-1:0] data_out;
    logic                data_valid_out;
    logic                data_ready_in;

    modport master (output data_out, output data_valid_out, input data_ready_in);
    modport slave  (input data_out, input data_valid_out, output data_ready_in);
endinterface

// File: rtl/adc_conv_sequencer_sync_edge.sv
// Two-flop synchroniser with rising-edge detect for flags crossing into this clock.
module adc_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic rise_out
);
    logic meta_q;
    logic sync_q;
    logic sync_d_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta_q   <= 1'b0;
            sync_q   <= 1'b0;
            sync_d_q <= 1'b0;
        end else begin
            meta_q   <= async_in;
            sync_q   <= meta_q;
            sync_d_q <= sync_q;
        end
    end

    assign rise_out = sync_q & ~sync_d_q;
endmodule

// File: rtl/adc_conv_sequencer.sv
// Sequences the SAR clock generator, averages 2^osr conversions per sample
// and delivers each sample over a valid/ready port.
module adc_conv_sequencer
    import adc_seq_pkg::*;
#(
    parameter int RESULT_W   = 12,
    parameter int ARM_CYCLES = 2,
    parameter int START_HOLD = 3,
    parameter int TIMEOUT    = 1024
) (
    input  logic                clk_vcm,
    input  logic                rst_n,
    input  logic                trig_in,
    input  logic                cfg_continuous,
    input  logic [PERIOD_W-1:0] cfg_period,
    input  logic [2:0]          cfg_osr,
    input  logic                cfg_enable_dlycontrol,
    input  logic [4:0]          cfg_dly1,
    input  logic [4:0]          cfg_dly2,
    input  logic [4:0]          cfg_dly3,
    input  logic [5:0]          cfg_dly4,
    input  logic                err_clr_in,
    input  logic                conv_finished_in,
    input  logic [RESULT_W-1:0] result_in,
    output logic                ena_out,
    output logic                start_conv_out,
    output logic                enable_dlycontrol_out,
    output logic [4:0]          dlycontrol1_out,
    output logic [4:0]          dlycontrol2_out,
    output logic [4:0]          dlycontrol3_out,
    output logic [5:0]          dlycontrol4_out,
    output logic                busy_out,
    output logic                timeout_err_out,
    output logic                overrun_err_out,
    output seq_state_t          state_dbg,
    adc_conv_sequencer_if.master dout
);
    localparam int ACC_W = acc_width(RESULT_W);
    localparam int TMO_W = tmo_width(TIMEOUT);
    localparam int PH_W  = 8;

    seq_state_t          state, state_nxt;
    logic [PH_W-1:0]     ph_cnt;
    logic [TMO_W-1:0]    tmo_cnt;
    logic [7:0]          conv_cnt;
    logic [2:0]          osr_q;
    logic [ACC_W-1:0]    acc;
    logic [RESULT_W-1:0] res_q;
    logic [PERIOD_W-1:0] per_cnt;
    logic [RESULT_W-1:0] data_q;
    logic                valid_q;

    logic                fin_rise;
    logic [PERIOD_W-1:0] per_lim;
    logic                launch;
    logic [7:0]          conv_last;
    logic                tmo_hit;
    logic                ovr_set;

    adc_sync_edge u_fin_sync (
        .clk      (clk_vcm),
        .rst_n    (rst_n),
        .async_in (conv_finished_in),
        .rise_out (fin_rise)
    );

    // A period of 0 behaves as 1, i.e. a new burst on every IDLE cycle.
    assign per_lim   = (cfg_period == '0) ? '0 : cfg_period - PERIOD_W'(1);
    assign launch    = trig_in | (cfg_continuous & (per_cnt >= per_lim));
    assign conv_last = (8'd1 << osr_q) - 8'd1;
    assign tmo_hit   = (state == WAIT) && !fin_rise && (tmo_cnt == TMO_W'(TIMEOUT - 1));
    assign ovr_set   = (state == DONE) && valid_q && !dout.data_ready_in;

    always_ff @(posedge clk_vcm) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (launch) state_nxt = ARM;
            ARM:     if (ph_cnt == PH_W'(ARM_CYCLES - 1)) state_nxt = START;
            START:   if (ph_cnt == PH_W'(START_HOLD - 1)) state_nxt = WAIT;
            WAIT: begin
                if (fin_rise)     state_nxt = CAPTURE;
                else if (tmo_hit) state_nxt = IDLE;
            end
            CAPTURE: state_nxt = (conv_cnt < conv_last) ? START : DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        ena_out        = 1'b0;
        start_conv_out = 1'b0;
        busy_out       = 1'b0;
        if (state != IDLE) begin
            ena_out  = 1'b1;
            busy_out = 1'b1;
        end
        if (state == START) start_conv_out = 1'b1;
    end

    assign state_dbg           = state;
    assign dout.data_out       = data_q;
    assign dout.data_valid_out = valid_q;

    always_ff @(posedge clk_vcm) begin
        if (!rst_n) begin
            ph_cnt                <= '0;
            tmo_cnt               <= '0;
            conv_cnt              <= '0;
            osr_q                 <= '0;
            acc                   <= '0;
            res_q                 <= '0;
            per_cnt               <= '0;
            data_q                <= '0;
            valid_q               <= 1'b0;
            timeout_err_out       <= 1'b0;
            overrun_err_out       <= 1'b0;
            enable_dlycontrol_out <= 1'b0;
            dlycontrol1_out       <= '0;
            dlycontrol2_out       <= '0;
            dlycontrol3_out       <= '0;
            dlycontrol4_out       <= '0;
        end else begin
            ph_cnt <= (state_nxt != state) ? '0 : ph_cnt + PH_W'(1);

            if (state == IDLE && state_nxt == ARM) begin
                per_cnt  <= '0;
                acc      <= '0;
                conv_cnt <= '0;
                osr_q    <= cfg_osr;
            end else if (per_cnt != '1) begin
                per_cnt <= per_cnt + PERIOD_W'(1);
            end

            if (state == START)     tmo_cnt <= '0;
            else if (state == WAIT) tmo_cnt <= tmo_cnt + TMO_W'(1);

            if (state == WAIT && fin_rise) res_q <= result_in;

            if (state == CAPTURE) begin
                acc <= acc + ACC_W'(res_q);
                if (conv_cnt < conv_last) conv_cnt <= conv_cnt + 8'd1;
            end

            // Generator delays may only change between bursts.
            if (state == IDLE) begin
                enable_dlycontrol_out <= cfg_enable_dlycontrol;
                dlycontrol1_out       <= cfg_dly1;
                dlycontrol2_out       <= cfg_dly2;
                dlycontrol3_out       <= cfg_dly3;
                dlycontrol4_out       <= cfg_dly4;
            end

            if (state == DONE) begin
                data_q  <= RESULT_W'(acc >> osr_q);
                valid_q <= 1'b1;
            end else if (valid_q && dout.data_ready_in) begin
                valid_q <= 1'b0;
            end

            if (tmo_hit)         timeout_err_out <= 1'b1;
            else if (err_clr_in) timeout_err_out <= 1'b0;

            if (ovr_set)         overrun_err_out <= 1'b1;
            else if (err_clr_in) overrun_err_out <= 1'b0;
        end
    end
endmodule

// File: tb/tb_adc_conv_sequencer.sv
// Bench for adc_conv_sequencer: a SAR responder answers start pulses and an
// averaging model predicts each sample.
module tb_adc_conv_sequencer;
    import adc_seq_pkg::*;

    localparam int RW = 12;

    logic          clk_vcm = 1'b0;
    logic          rst_n = 1'b0;
    logic          trig_in = 1'b0;
    logic          cfg_continuous = 1'b0;
    logic [15:0]   cfg_period = 16'd1;
    logic [2:0]    cfg_osr = 3'd0;
    logic          cfg_enable_dlycontrol = 1'b0;
    logic [4:0]    cfg_dly1 = 5'd5;
    logic [4:0]    cfg_dly2 = 5'd0;
    logic [4:0]    cfg_dly3 = 5'd0;
    logic [5:0]    cfg_dly4 = 6'd0;
    logic          err_clr_in = 1'b0;
    logic          conv_finished_in = 1'b0;
    logic [RW-1:0] result_in = '0;
    logic          ena_out, start_conv_out, enable_dlycontrol_out;
    logic [4:0]    dlycontrol1_out, dlycontrol2_out, dlycontrol3_out;
    logic [5:0]    dlycontrol4_out;
    logic          busy_out, timeout_err_out, overrun_err_out;
    seq_state_t    state_dbg;

    adc_conv_sequencer_if #(.RESULT_W(RW)) dout_if ();

    adc_conv_sequencer #(
        .RESULT_W(RW), .ARM_CYCLES(2), .START_HOLD(3), .TIMEOUT(1024)
    ) dut (
        .clk_vcm               (clk_vcm),
        .rst_n                 (rst_n),
        .trig_in               (trig_in),
        .cfg_continuous        (cfg_continuous),
        .cfg_period            (cfg_period),
        .cfg_osr               (cfg_osr),
        .cfg_enable_dlycontrol (cfg_enable_dlycontrol),
        .cfg_dly1              (cfg_dly1),
        .cfg_dly2              (cfg_dly2),
        .cfg_dly3              (cfg_dly3),
        .cfg_dly4              (cfg_dly4),
        .err_clr_in            (err_clr_in),
        .conv_finished_in      (conv_finished_in),
        .result_in             (result_in),
        .ena_out               (ena_out),
        .start_conv_out        (start_conv_out),
        .enable_dlycontrol_out (enable_dlycontrol_out),
        .dlycontrol1_out       (dlycontrol1_out),
        .dlycontrol2_out       (dlycontrol2_out),
        .dlycontrol3_out       (dlycontrol3_out),
        .dlycontrol4_out       (dlycontrol4_out),
        .busy_out              (busy_out),
        .timeout_err_out       (timeout_err_out),
        .overrun_err_out       (overrun_err_out),
        .state_dbg             (state_dbg),
        .dout                  (dout_if)
    );

    // ---------------- clock ----------------
    always #5 clk_vcm = ~clk_vcm;

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- start-pulse monitor ----------------
    int   cyc = 0;
    int   start_rises = 0;
    logic start_d = 1'b0;
    int   start_cyc_q[$];

    always @(negedge clk_vcm) begin
        cyc++;
        if (start_conv_out && !start_d) begin
            start_rises++;
            start_cyc_q.push_back(cyc);
        end
        start_d = start_conv_out;
    end

    // ---------------- SAR responder ----------------
    int            fin_delay = 20;
    bit            fin_block = 1'b0;
    int            resp_seen = 0;
    logic [RW-1:0] plan_q[$];

    initial begin
        forever begin
            @(negedge clk_vcm);
            if (start_rises != resp_seen) begin
                resp_seen = start_rises;
                if (!fin_block) begin
                    repeat (fin_delay) @(negedge clk_vcm);
                    result_in = (plan_q.size() > 0) ? plan_q.pop_front() : RW'($urandom_range(0, 4095));
                    conv_finished_in = 1'b1;
                    repeat (2) @(negedge clk_vcm);
                    conv_finished_in = 1'b0;
                end
            end
        end
    end

    // ---------------- consumer and scoreboard ----------------
    bit            rand_ready = 1'b0;
    logic [RW-1:0] exp_q[$];

    always @(negedge clk_vcm) begin
        if (rand_ready) dout_if.data_ready_in = 1'($urandom_range(0, 1));
    end

    always @(negedge clk_vcm) begin
        #2;
        if (rst_n && dout_if.data_valid_out && dout_if.data_ready_in) begin
            if (exp_q.size() == 0) check_val("sb_pending", 32'(exp_q.size()), 32'd1);
            else check_val("sb_data", 32'(dout_if.data_out), 32'(exp_q.pop_front()));
        end
    end

    // Average model: mean of the planned results, truncated.
    task automatic run_burst(input int osr, input string tag);
        int n, t, gap, base, ena_first, start_first, start_len;
        bit start_done;
        logic [RW+6:0] sum;
        n = 1 << osr;
        sum = '0;
        foreach (plan_q[i]) sum += (RW+7)'(plan_q[i]);
        exp_q.push_back(RW'(sum >> osr));
        cfg_osr = 3'(osr);
        base = start_rises; gap = 0; t = 0;
        ena_first = -1; start_first = -1; start_len = 0; start_done = 1'b0;
        trig_in = 1'b1;
        while (t < n * 80 + 200) begin
            @(negedge clk_vcm);
            trig_in = 1'b0;
            t++;
            if (dout_if.data_valid_out) break;
            if (ena_out && ena_first < 0) ena_first = t;
            if (ena_first >= 0 && !ena_out) gap++;
            if (start_conv_out && start_first < 0) start_first = t;
            if (start_first >= 0 && !start_done) begin
                if (start_conv_out) start_len++;
                else start_done = 1'b1;
            end
        end
        check_val({tag, "_valid"}, 32'(dout_if.data_valid_out), 32'd1);
        check_val({tag, "_starts"}, 32'(start_rises - base), 32'(n));
        check_val({tag, "_ena_gap"}, 32'(gap), 32'd0);
        check_val({tag, "_arm_lead"}, 32'(start_first - ena_first), 32'd2);
        check_val({tag, "_start_len"}, 32'(start_len), 32'd3);
        check_val({tag, "_ena_end"}, 32'(ena_out), 32'd0);
    endtask

    task automatic run_timeout(input bit clr_on_set, input string tag);
        int t, w;
        fin_block = 1'b1;
        trig_in = 1'b1;
        @(negedge clk_vcm);
        trig_in = 1'b0;
        t = 0;
        while (!start_conv_out && t < 20) begin @(negedge clk_vcm); t++; end
        while (start_conv_out && t < 40) begin @(negedge clk_vcm); t++; end
        w = 0;
        while (!timeout_err_out && w < 1100) begin
            if (clr_on_set && w == 1023) err_clr_in = 1'b1;
            @(negedge clk_vcm);
            err_clr_in = 1'b0;
            w++;
        end
        check_val({tag, "_wait_cycles"}, 32'(w), 32'd1024);
        check_val({tag, "_err"}, 32'(timeout_err_out), 32'd1);
        check_val({tag, "_ena"}, 32'(ena_out), 32'd0);
        check_val({tag, "_busy"}, 32'(busy_out), 32'd0);
        check_val({tag, "_valid"}, 32'(dout_if.data_valid_out), 32'd0);
        fin_block = 1'b0;
    endtask

    // ---------------- main sequence ----------------
    int            t, w2, idle_len, seen_v, nb, osr_r;
    logic [RW-1:0] a_val, b_val;

    initial begin
        dout_if.data_ready_in = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk_vcm);
        check_val("rst_ena", 32'(ena_out), 32'd0);
        check_val("rst_start", 32'(start_conv_out), 32'd0);
        check_val("rst_busy", 32'(busy_out), 32'd0);
        check_val("rst_valid", 32'(dout_if.data_valid_out), 32'd0);
        check_val("rst_dly1", 32'(dlycontrol1_out), 32'd0);
        check_val("rst_errs", 32'({timeout_err_out, overrun_err_out}), 32'd0);
        rst_n = 1'b1;
        dout_if.data_ready_in = 1'b1;
        repeat (3) @(negedge clk_vcm);

        // single shot
        fin_delay = 20;
        plan_q.push_back(12'hA5C);
        run_burst(0, "shot");
        check_val("shot_data", 32'(dout_if.data_out), 32'h0A5C);

        // averaging
        fin_delay = 5;
        for (int i = 0; i < 4; i++) plan_q.push_back(RW'(100 + i));
        run_burst(2, "avg");
        check_val("avg_data", 32'(dout_if.data_out), 32'd101);

        fin_delay = 3;
        for (int i = 0; i < 128; i++) plan_q.push_back(12'hFFF);
        run_burst(7, "full");
        check_val("full_data", 32'(dout_if.data_out), 32'h0FFF);

        // configuration freeze during a burst
        cfg_dly1 = 5'd5;
        cfg_dly2 = 5'($urandom_range(0, 31));
        cfg_dly3 = 5'($urandom_range(0, 31));
        cfg_dly4 = 6'($urandom_range(0, 63));
        cfg_enable_dlycontrol = 1'b1;
        repeat (2) @(negedge clk_vcm);
        check_val("dly_idle", 32'({enable_dlycontrol_out, dlycontrol1_out, dlycontrol2_out, dlycontrol3_out, dlycontrol4_out}),
                  32'({1'b1, 5'd5, cfg_dly2, cfg_dly3, cfg_dly4}));
        fin_delay = 20;
        plan_q.push_back(RW'($urandom_range(0, 4095)));
        fork
            run_burst(0, "frz");
            begin
                w2 = 0;
                while (!busy_out && w2 < 20) begin @(negedge clk_vcm); w2++; end
                cfg_dly1 = 5'd9;
                repeat (5) @(negedge clk_vcm);
                check_val("dly1_frozen", 32'(dlycontrol1_out), 32'd5);
                check_val("frz_busy", 32'(busy_out), 32'd1);
            end
        join
        repeat (2) @(negedge clk_vcm);
        check_val("dly1_updated", 32'(dlycontrol1_out), 32'd9);

        // randomized bursts with a random-ready consumer
        rand_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            osr_r = $urandom_range(0, 3);
            fin_delay = $urandom_range(1, 30);
            for (int j = 0; j < (1 << osr_r); j++) plan_q.push_back(RW'($urandom_range(0, 4095)));
            run_burst(osr_r, "rnd");
            t = 0;
            while (dout_if.data_valid_out && t < 200) begin @(negedge clk_vcm); t++; end
            check_val("rnd_drain", 32'(dout_if.data_valid_out), 32'd0);
        end
        rand_ready = 1'b0;
        dout_if.data_ready_in = 1'b1;
        @(negedge clk_vcm);

        // timeout, clear, then set and clear in the same cycle
        run_timeout(1'b0, "tmo");
        err_clr_in = 1'b1;
        @(negedge clk_vcm);
        err_clr_in = 1'b0;
        check_val("tmo_cleared", 32'(timeout_err_out), 32'd0);
        run_timeout(1'b1, "tmo_setwins");
        err_clr_in = 1'b1;
        @(negedge clk_vcm);
        err_clr_in = 1'b0;

        // continuous, period 200, consumer stalled
        dout_if.data_ready_in = 1'b0;
        fin_delay = 20;
        cfg_osr = 3'd0;
        a_val = RW'($urandom_range(0, 4095));
        b_val = RW'($urandom_range(0, 4095));
        plan_q.push_back(a_val);
        plan_q.push_back(b_val);
        cfg_period = 16'd200;
        cfg_continuous = 1'b1;
        t = 0;
        while (!dout_if.data_valid_out && t < 300) begin @(negedge clk_vcm); t++; end
        check_val("cont_first_valid", 32'(dout_if.data_valid_out), 32'd1);
        check_val("cont_first_data", 32'(dout_if.data_out), 32'(a_val));
        t = 0;
        while (!overrun_err_out && t < 400) begin @(negedge clk_vcm); t++; end
        check_val("ovr_set", 32'(overrun_err_out), 32'd1);
        check_val("ovr_data", 32'(dout_if.data_out), 32'(b_val));
        check_val("ovr_valid", 32'(dout_if.data_valid_out), 32'd1);
        check_val("period_gap", 32'(start_cyc_q[$] - start_cyc_q[$-1]), 32'd200);
        cfg_continuous = 1'b0;
        nb = 0;
        repeat (250) begin @(negedge clk_vcm); if (busy_out) nb++; end
        check_val("cont_stopped", 32'(nb), 32'd0);
        exp_q.push_back(b_val);
        dout_if.data_ready_in = 1'b1;
        repeat (3) @(negedge clk_vcm);
        check_val("ovr_drained", 32'(exp_q.size()), 32'd0);
        err_clr_in = 1'b1;
        @(negedge clk_vcm);
        err_clr_in = 1'b0;
        check_val("ovr_cleared", 32'(overrun_err_out), 32'd0);

        // period 0: back-to-back bursts, stop mid-burst
        fin_delay = 3;
        cfg_period = 16'd0;
        for (int i = 0; i < 3; i++) begin
            a_val = RW'($urandom_range(0, 4095));
            plan_q.push_back(a_val);
            exp_q.push_back(a_val);
        end
        cfg_continuous = 1'b1;
        t = 0;
        while (!busy_out && t < 10) begin @(negedge clk_vcm); t++; end
        for (int g = 0; g < 2; g++) begin
            t = 0;
            while (busy_out && t < 200) begin @(negedge clk_vcm); t++; end
            idle_len = 0;
            while (!busy_out && idle_len < 20) begin idle_len++; @(negedge clk_vcm); end
            check_val("b2b_idle", 32'(idle_len), 32'd1);
        end
        cfg_continuous = 1'b0;
        t = 0;
        while (busy_out && t < 200) begin @(negedge clk_vcm); t++; end
        repeat (20) @(negedge clk_vcm);
        check_val("b2b_busy_end", 32'(busy_out), 32'd0);
        check_val("b2b_samples", 32'(exp_q.size()), 32'd0);

        // reset while waiting for a conversion
        fin_delay = 20;
        plan_q.push_back(12'h3C3);
        trig_in = 1'b1;
        @(negedge clk_vcm);
        trig_in = 1'b0;
        t = 0;
        while (!start_conv_out && t < 20) begin @(negedge clk_vcm); t++; end
        while (start_conv_out && t < 40) begin @(negedge clk_vcm); t++; end
        repeat (5) @(negedge clk_vcm);
        rst_n = 1'b0;
        @(negedge clk_vcm);
        check_val("mrst_ena_start", 32'({ena_out, start_conv_out}), 32'd0);
        check_val("mrst_busy", 32'(busy_out), 32'd0);
        check_val("mrst_data", 32'({dout_if.data_valid_out, dout_if.data_out}), 32'd0);
        check_val("mrst_dly1", 32'(dlycontrol1_out), 32'd0);
        rst_n = 1'b1;
        seen_v = 0;
        nb = 0;
        repeat (60) begin
            @(negedge clk_vcm);
            if (dout_if.data_valid_out) seen_v++;
            if (busy_out) nb++;
        end
        check_val("mrst_no_valid", 32'(seen_v), 32'd0);
        check_val("mrst_no_busy", 32'(nb), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
